// File: rtl/bytebeat_mixer_pwm_if.sv
// Channel-side PCM bus for the bytebeat mixer: per-channel samples, valid,
// ready and mix-enable, grouped so the generator array binds in one port.
interface bytebeat_mixer_pwm_if #(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 8
);
    logic [NUM_CH*SAMPLE_W-1:0] ch_pcm;
    logic [NUM_CH-1:0]          ch_vld;
    logic [NUM_CH-1:0]          ch_rdy;
    logic [NUM_CH-1:0]          ch_en;

    modport master (output ch_pcm, output ch_vld, output ch_en, input ch_rdy);
    modport slave  (input ch_pcm, input ch_vld, input ch_en, output ch_rdy);
endinterface

// File: rtl/bytebeat_mixer_pwm.sv
// N-channel PCM mixer with a single PWM DAC output.
// Each channel owns a one-deep hold buffer that is promoted to its play
// register on the sample tick; the enabled play registers are summed, scaled
// (average or saturate) and fed to a PWM whose duty only reloads at wrap.

// One input channel: hold buffer, full flag and sample-and-hold play register.
module bytebeat_mixer_pwm_lane #(
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] pcm,
    input  logic                vld,
    input  logic                tick,
    output logic                full,
    output logic [SAMPLE_W-1:0] play
);
    logic [SAMPLE_W-1:0] hold;

    // Tick drains a full buffer into play; otherwise an empty buffer accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
            full <= 1'b0;
            play <= '0;
        end else if (tick && full) begin
            play <= hold;
            full <= 1'b0;
        end else if (vld && !full) begin
            hold <= pcm;
            full <= 1'b1;
        end
    end
endmodule

module bytebeat_mixer_pwm #(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 8,
    parameter int PWM_W    = 8,
    parameter int RATE_DIV = 3125
) (
    input  logic                  clk,
    input  logic                  reset,
    bytebeat_mixer_pwm_if.slave   ch,
    input  logic                  mix_mode,
    input  logic                  underrun_clr,
    output logic                  sample_tick,
    output logic [PWM_W-1:0]      mix_out,
    output logic                  underrun,
    output logic                  pwm_out
);
    localparam int SUM_W  = SAMPLE_W + $clog2(NUM_CH);
    localparam int CNT_W  = $clog2(RATE_DIV);
    localparam int STAGES = 1;
    localparam logic [SUM_W-1:0] PWM_MAX   = SUM_W'((2 ** PWM_W) - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(RATE_DIV - 1);

    logic [CNT_W-1:0]                 tick_cnt;
    logic [NUM_CH-1:0]                full;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]  play;
    logic [SUM_W-1:0]                 sum_nxt;
    logic [SUM_W-1:0]                 sum_q;
    logic [STAGES:0]                  vld_pipe;
    logic [PWM_W-1:0]                 pwm_cnt;
    logic [PWM_W-1:0]                 duty;

    assign sample_tick = !reset && (tick_cnt == TICK_LAST);
    assign ch.ch_rdy   = ~full & {NUM_CH{~reset}};

    // Sample-period divider: counts 0..RATE_DIV-1 and wraps on the tick.
    always_ff @(posedge clk) begin
        if (reset || sample_tick) tick_cnt <= '0;
        else                      tick_cnt <= tick_cnt + 1'b1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        bytebeat_mixer_pwm_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
            .clk   (clk),
            .reset (reset),
            .pcm   (ch.ch_pcm[g*SAMPLE_W +: SAMPLE_W]),
            .vld   (ch.ch_vld[g]),
            .tick  (sample_tick),
            .full  (full[g]),
            .play  (play[g])
        );
    end

    // Full-width sum of the enabled play registers; cannot overflow SUM_W.
    always_comb begin
        sum_nxt = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch.ch_en[i]) sum_nxt = sum_nxt + SUM_W'(play[i]);
    end

    // Tick marker shifts down the two mix stages (sum, then scale).
    always_ff @(posedge clk) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-1:0], sample_tick};
    end

    // Stage 1 captures the sum once play has settled; stage 2 scales it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q   <= '0;
            mix_out <= '0;
        end else begin
            if (vld_pipe[0]) sum_q <= sum_nxt;
            if (vld_pipe[1]) begin
                if (mix_mode) mix_out <= (sum_q > PWM_MAX) ? '1 : sum_q[PWM_W-1:0];
                else          mix_out <= sum_q[SUM_W-1 -: PWM_W];
            end
        end
    end

    // Sticky starvation flag; a new starvation outranks a clear.
    always_ff @(posedge clk) begin
        if (reset)                                       underrun <= 1'b0;
        else if (sample_tick && |(ch.ch_en & ~full))     underrun <= 1'b1;
        else if (underrun_clr)                           underrun <= 1'b0;
    end

    // PWM: duty reloads only as the counter wraps so no period is truncated.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == '1) duty <= mix_out;
            pwm_out <= (pwm_cnt < duty);
        end
    end
endmodule

// File: tb/tb_bytebeat_mixer_pwm.sv
// Self-checking bench for bytebeat_mixer_pwm: randomized samples checked
// against an arithmetic model of the mix (sum of enabled channels, then
// average or clamp) and against run-length rules for the PWM output.
module tb_bytebeat_mixer_pwm;
    localparam int NUM_CH   = 8;
    localparam int SAMPLE_W = 8;
    localparam int PWM_W    = 8;
    localparam int RATE_DIV = 300;
    localparam int PMAX     = (1 << PWM_W) - 1;

    logic clk = 1'b0;
    logic reset, mix_mode, underrun_clr;
    logic sample_tick, underrun, pwm_out;
    logic [PWM_W-1:0] mix_out;

    int n_chk = 0;
    int n_fail = 0;
    int play_m [NUM_CH];

    bytebeat_mixer_pwm_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) bus ();

    bytebeat_mixer_pwm #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .PWM_W(PWM_W), .RATE_DIV(RATE_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ch           (bus),
        .mix_mode     (mix_mode),
        .underrun_clr (underrun_clr),
        .sample_tick  (sample_tick),
        .mix_out      (mix_out),
        .underrun     (underrun),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    // Reference mix: plain sum of last-played samples on enabled channels.
    function automatic int mix_ref(input logic [NUM_CH-1:0] en, input logic mode);
        int sum = 0;
        for (int i = 0; i < NUM_CH; i++) if (en[i]) sum += play_m[i];
        if (mode) return (sum > PMAX) ? PMAX : sum;
        return sum / NUM_CH;
    endfunction

    task automatic wait_tick(output int waited);
        waited = 0;
        n_chk++;
        do begin
            @(negedge clk);
            waited++;
        end while (sample_tick !== 1'b1 && waited < 2 * RATE_DIV);
        if (sample_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_timeout: no sample_tick after %0d cycles", waited);
        end
    endtask

    task automatic push(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*SAMPLE_W-1:0] data);
        bus.ch_pcm = data;
        bus.ch_vld = mask;
        @(negedge clk);
        bus.ch_vld = '0;
    endtask

    // Push, wait for the tick that plays it, land on the cycle mix_out is new.
    task automatic push_and_play(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*SAMPLE_W-1:0] data);
        int w;
        push(mask, data);
        wait_tick(w);
        repeat (3) @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) if (mask[i]) play_m[i] = int'(data[i*SAMPLE_W +: SAMPLE_W]);
    endtask

    task automatic test_reset;
        int w;
        reset = 1'b1; mix_mode = 1'b0; underrun_clr = 1'b0;
        bus.ch_pcm = '0; bus.ch_vld = '0; bus.ch_en = '0;
        for (int i = 0; i < NUM_CH; i++) play_m[i] = 0;
        repeat (5) @(negedge clk);
        n_chk++;
        if ({bus.ch_rdy, sample_tick, mix_out, underrun, pwm_out} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%h tick=%b mix=%0d und=%b pwm=%b, required all 0",
                     bus.ch_rdy, sample_tick, mix_out, underrun, pwm_out);
        end
        reset = 1'b0;
        #1;
        n_chk++;
        if (bus.ch_rdy !== 8'hFF) begin n_fail++; $display("FAIL rdy_release: got %h expected ff", bus.ch_rdy); end
        wait_tick(w);
        n_chk++;
        if (w !== RATE_DIV - 1) begin n_fail++; $display("FAIL first_tick: tick in cycle %0d expected %0d", w + 1, RATE_DIV); end
        @(negedge clk);
        n_chk++;
        if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL tick_pulse: got %b expected 0", sample_tick); end
    endtask

    task automatic test_average;
        int w;
        logic [NUM_CH*SAMPLE_W-1:0] d;
        for (int i = 0; i < NUM_CH; i++) d[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(8 * (i + 1));
        bus.ch_en = '1; mix_mode = 1'b0;
        push('1, d);
        n_chk++;
        if (bus.ch_rdy !== 8'h00) begin n_fail++; $display("FAIL rdy_full: got %h expected 00", bus.ch_rdy); end
        wait_tick(w);
        n_chk++;
        if (bus.ch_rdy !== 8'h00) begin n_fail++; $display("FAIL rdy_at_tick: got %h expected 00", bus.ch_rdy); end
        @(negedge clk);
        n_chk++;
        if (bus.ch_rdy !== 8'hFF) begin n_fail++; $display("FAIL rdy_after_tick: got %h expected ff", bus.ch_rdy); end
        n_chk++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL avg_underrun: got %b expected 0", underrun); end
        @(negedge clk);
        n_chk++;
        if (mix_out !== 8'd0) begin n_fail++; $display("FAIL mix_latency: got %0d expected 0 one cycle early", mix_out); end
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) play_m[i] = 8 * (i + 1);
        n_chk++;
        if (mix_out !== 8'd36) begin n_fail++; $display("FAIL avg_mix: got %0d expected 36", mix_out); end
    endtask

    task automatic test_random_mix;
        logic [NUM_CH*SAMPLE_W-1:0] d;
        logic [NUM_CH-1:0] en;
        logic mode;
        int e;
        for (int r = 0; r < 6; r++) begin
            en = NUM_CH'($urandom);
            mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < NUM_CH; i++) d[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom_range(0, 255));
            bus.ch_en = en; mix_mode = mode;
            push_and_play('1, d);
            e = mix_ref(en, mode);
            n_chk++;
            if (mix_out !== PWM_W'(e)) begin
                n_fail++;
                $display("FAIL rand_mix[%0d]: en=%h mode=%b got %0d expected %0d", r, en, mode, mix_out, e);
            end
            n_chk++;
            if (underrun !== 1'b0) begin n_fail++; $display("FAIL rand_underrun[%0d]: got %b expected 0", r, underrun); end
        end
    endtask

    task automatic test_saturate;
        logic [NUM_CH*SAMPLE_W-1:0] d;
        for (int i = 0; i < NUM_CH; i++) d[i*SAMPLE_W +: SAMPLE_W] = 8'd200;
        bus.ch_en = '1; mix_mode = 1'b1;
        push_and_play('1, d);
        n_chk++;
        if (mix_out !== 8'd255) begin n_fail++; $display("FAIL sat_mix: got %0d expected 255", mix_out); end
        bus.ch_en = 8'h01;
        d = '0; d[7:0] = 8'd100;
        push_and_play(8'h01, d);
        n_chk++;
        if (mix_out !== 8'd100) begin n_fail++; $display("FAIL sat_single: got %0d expected 100", mix_out); end
    endtask

    task automatic test_starvation;
        int w, v, v2;
        logic [NUM_CH*SAMPLE_W-1:0] d;
        v = $urandom_range(1, 255);
        bus.ch_en = 8'h08; mix_mode = 1'b1;
        d = '0; d[3*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(v);
        push_and_play(8'h08, d);
        n_chk++;
        if (mix_out !== PWM_W'(v) || underrun !== 1'b0) begin
            n_fail++; $display("FAIL starve_setup: got mix=%0d und=%b expected mix=%0d und=0", mix_out, underrun, v);
        end
        wait_tick(w);
        @(negedge clk);
        n_chk++;
        if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b expected 1", underrun); end
        repeat (2) @(negedge clk);
        n_chk++;
        if (mix_out !== PWM_W'(v)) begin n_fail++; $display("FAIL replay: got %0d expected %0d", mix_out, v); end
        wait_tick(w);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        n_chk++;
        if (underrun !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr: got %b expected 1", underrun); end
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        n_chk++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clr: got %b expected 0", underrun); end
        v2 = $urandom_range(0, 255);
        d = '0; d[3*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(v2);
        push_and_play(8'h08, d);
        n_chk++;
        if (underrun !== 1'b0 || mix_out !== PWM_W'(v2)) begin
            n_fail++; $display("FAIL fed_tick: got und=%b mix=%0d expected und=0 mix=%0d", underrun, mix_out, v2);
        end
    endtask

    task automatic test_pwm_duty;
        int highs;
        logic [NUM_CH*SAMPLE_W-1:0] d;
        bus.ch_en = 8'h01; mix_mode = 1'b1;
        d = '0; d[7:0] = 8'd64;
        push_and_play(8'h01, d);
        repeat (260) @(negedge clk);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) highs++;
        end
        n_chk++;
        if (highs !== 64) begin n_fail++; $display("FAIL pwm_duty64: got %0d high of 256 expected 64", highs); end
    endtask

    task automatic test_pwm_change;
        int w, idx_t, run, run_s, n_old, n_new, exp_len;
        logic [NUM_CH*SAMPLE_W-1:0] d;
        d = '0; d[7:0] = 8'd250;
        push_and_play(8'h01, d);
        wait_tick(w);
        repeat (3) @(negedge clk);
        bus.ch_pcm = '0; bus.ch_pcm[7:0] = 8'd30; bus.ch_vld = 8'h01;
        idx_t = -1; run = (pwm_out === 1'b1) ? 1 : 0; run_s = 0; n_old = 0; n_new = 0;
        for (int i = 1; i < 900; i++) begin
            @(negedge clk);
            if (i == 1) bus.ch_vld = '0;
            if (idx_t < 0 && sample_tick === 1'b1) idx_t = i;
            if (pwm_out === 1'b1) begin
                if (run == 0) run_s = i;
                run++;
            end else if (run != 0) begin
                exp_len = -1;
                if (run_s > 0 && (idx_t < 0 || run_s <= idx_t + 4)) begin exp_len = 250; n_old++; end
                else if (run_s > 0) begin exp_len = 30; n_new++; end
                if (exp_len >= 0) begin
                    n_chk++;
                    if (run !== exp_len) begin
                        n_fail++;
                        $display("FAIL pwm_run@%0d: got %0d high cycles expected %0d (tick@%0d)", run_s, run, exp_len, idx_t);
                    end
                end
                run = 0;
            end
        end
        n_chk++;
        if (idx_t < 0 || n_old == 0 || n_new == 0) begin
            n_fail++; $display("FAIL pwm_runs_seen: tick=%0d old=%0d new=%0d expected all present", idx_t, n_old, n_new);
        end
        n_chk++;
        if (mix_out !== 8'd30) begin n_fail++; $display("FAIL pwm_new_mix: got %0d expected 30", mix_out); end
    endtask

    task automatic test_reset_mid;
        int w, highs;
        logic [NUM_CH*SAMPLE_W-1:0] d;
        bus.ch_en = 8'h0F; mix_mode = 1'b0;
        wait_tick(w);
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) d[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom_range(1, 255));
        push(8'h0F, d);
        n_chk++;
        if (bus.ch_rdy !== 8'hF0) begin n_fail++; $display("FAIL mid_full: got %h expected f0", bus.ch_rdy); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus.ch_rdy, sample_tick, mix_out, underrun, pwm_out} !== 19'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got rdy=%h tick=%b mix=%0d und=%b pwm=%b, required all 0",
                     bus.ch_rdy, sample_tick, mix_out, underrun, pwm_out);
        end
        reset = 1'b0;
        for (int i = 0; i < NUM_CH; i++) play_m[i] = 0;
        #1;
        n_chk++;
        if (bus.ch_rdy !== 8'hFF) begin n_fail++; $display("FAIL mid_rdy: got %h expected ff", bus.ch_rdy); end
        @(negedge clk);
        n_chk++;
        if (mix_out !== 8'd0 || underrun !== 1'b0) begin
            n_fail++; $display("FAIL mid_release: got mix=%0d und=%b expected 0 0", mix_out, underrun);
        end
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) highs++;
        end
        n_chk++;
        if (highs !== 0) begin n_fail++; $display("FAIL pwm_duty0: got %0d high expected 0", highs); end
        wait_tick(w);
        @(negedge clk);
        n_chk++;
        if (underrun !== 1'b1) begin n_fail++; $display("FAIL mid_underrun: got %b expected 1", underrun); end
        repeat (2) @(negedge clk);
        n_chk++;
        if (mix_out !== PWM_W'(mix_ref(8'h0F, 1'b0))) begin
            n_fail++; $display("FAIL mid_mix: got %0d expected %0d", mix_out, mix_ref(8'h0F, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_average();
        test_random_mix();
        test_saturate();
        test_starvation();
        test_pwm_duty();
        test_pwm_change();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
